data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Memory-side slave for the shared data bus. It terminates the Mem_DataMem_* side of the bus and serves single-word reads and byte-masked writes from an on-chip synchronous RAM. Response timing is a programmable wait-state count, so the arbitration path can be exercised with realistic memory latency. Out-of-window and malformed accesses are completed with an error pulse, so the bus never hangs.

Parameters:
ADDR_WIDTH, 10, word-address bits decoded into the RAM; depth is 2**ADDR_WIDTH words.
WAIT_CYCLES, 2, extra wait cycles before the RAM access, range 0..15.
BASE_ADDR, 30'h0, word base address of the window; must be aligned to 2**ADDR_WIDTH.

Ports:
clock  in  1  system clock; all state is updated on the rising edge.
reset  in  1  asynchronous, active-high reset.
DataMem_Read  in  1  read request; a level held by the requester.
DataMem_Write  in  4  byte write enables; bit 3 maps to data[31:24], bit 0 maps to data[7:0].
DataMem_Address  in  30  word address.
DataMem_Out  in  32  write data from the bus.
DataMem_In  out  32  read data returned to the bus.
DataMem_Ready  out  1  one-cycle completion pulse.
Bus_Error  out  1  one-cycle pulse, coincident with Ready, marking an errored transaction.

Interface note:
One clock; reset is asynchronous and active-high (ports clock and reset).

Behaviour:
- Reset values: DataMem_In=0, DataMem_Ready=0, Bus_Error=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Request: a request is Read=1 or |Write=1, sampled only in IDLE. On that edge the controller latches address, write data, byte enables and type. The request lines are then ignored until the transaction completes; dropping them mid-transaction does not abort it.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE -> WAIT when a request is seen and WAIT_CYCLES>0, loading counter=WAIT_CYCLES. IDLE -> ACCESS when a request is seen and WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
- ACCESS: a write updates the enabled bytes at the end of this cycle; a read issues the RAM read. Next state is RESP.
- RESP: DataMem_Ready=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency: a request first present in cycle 0 (FSM in IDLE) produces Ready in cycle WAIT_CYCLES+2. With the default that is cycle 4.
- Back-to-back: IDLE re-samples the cycle after RESP. A request still held then is a new transaction, so the requester must change or drop its request the cycle after Ready. Peak throughput is one transaction per WAIT_CYCLES+3 cycles.
- Read data: DataMem_In is registered and changes only in RESP of a successful read. It holds its value through writes and errored accesses.
- Window decode: the access is in range iff Address[29:ADDR_WIDTH] == BASE_ADDR[29:ADDR_WIDTH]. The RAM index is Address[ADDR_WIDTH-1:0].
- Error cases: an out-of-range access, or Read=1 together with |Write=1, takes the same latency path. No RAM write occurs, DataMem_In is left unchanged, and Bus_Error=1 in RESP together with Ready.
- Byte-mask write: Write=4'b0000 with Read=0 is not a request. Any nonzero mask writes only the enabled lanes; the other bytes keep their old value.
- Read-after-write to the same word in consecutive transactions returns the new data; there is no bypass hazard because the transactions are serialised.
- Reset mid-transaction: the FSM returns to IDLE and Ready/Error are cleared immediately (asynchronous). A write commits only if its ACCESS edge completed before reset. After reset is released, a still-held request is treated as new.
- Counter width is 4 bits. WAIT_CYCLES=0 skips WAIT entirely.

Test Plan:
- Default params, write Addr=0x5, Write=4'hF, Out=0xDEADBEEF at cycle 0 -> Ready=1 in cycle 4, Error=0. A read of 0x5 then returns In=0xDEADBEEF with Ready in its cycle 4.
- Partial write: after the above, write Write=4'b0100, Out=0x00AA0000 to 0x5 -> a read of 0x5 returns 0xDEAABEEF.
- Latency sweep: WAIT_CYCLES=0 and 7 -> Ready exactly in cycle 2 and cycle 9 respectively, high for one cycle. Back-to-back reads of 0x1 and 0x2 are spaced WAIT+3 cycles apart.
- Errors with ADDR_WIDTH=10, BASE=0: read of 0x400 -> Ready=1 and Error=1 in cycle 4, In unchanged. Read=1 with Write=4'h1 at 0x3 -> error, and word 0x3 is unmodified.
- Reset mid-op: assert reset in the WAIT state of a write of 0x12345678 to 0x9 -> Ready stays 0, and a later read of 0x9 returns the old value. Reset during RESP forces Ready to 0 within the same cycle.
- Abandoned request: Read is dropped in cycle 1 -> Ready still fires in cycle 4 and the FSM returns to IDLE with no extra transaction.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Memory-side slave for the shared data bus: single-word reads and byte-masked
// writes into an on-chip RAM, with a fixed wait-state count and error completion.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [29:0] BASE_ADDR   = 30'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DataMem_Read,
  input  logic [3:0]  DataMem_Write,
  input  logic [29:0] DataMem_Address,
  input  logic [31:0] DataMem_Out,
  output logic [31:0] DataMem_In,
  output logic        DataMem_Ready,
  output logic        Bus_Error
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_is_read;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic w_req;
  logic w_in_range;
  logic w_bad;
  logic w_mem_we;

  assign w_req      = DataMem_Read | (|DataMem_Write);
  assign w_in_range = (DataMem_Address[29:ADDR_WIDTH] == BASE_ADDR[29:ADDR_WIDTH]);
  assign w_bad      = ~w_in_range | (DataMem_Read & (|DataMem_Write));
  // Derived from state so an asynchronous reset cancels a pending write at once.
  assign w_mem_we   = (r_state == S_ACCESS) && !r_is_read && !r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_idx         <= '0;
      r_wdata       <= 32'd0;
      r_be          <= 4'd0;
      r_is_read     <= 1'b0;
      r_err         <= 1'b0;
      DataMem_In    <= 32'd0;
      DataMem_Ready <= 1'b0;
      Bus_Error     <= 1'b0;
    end else begin
      DataMem_Ready <= 1'b0;
      Bus_Error     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx     <= DataMem_Address[ADDR_WIDTH-1:0];
            r_wdata   <= DataMem_Out;
            r_be      <= DataMem_Write;
            r_is_read <= DataMem_Read;
            r_err     <= w_bad;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_cnt   <= WAIT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_is_read && !r_err) DataMem_In <= r_mem[r_idx];
          DataMem_Ready <= 1'b1;
          Bus_Error     <= r_err;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM array is intentionally not reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: default-parameter instance plus
// WAIT_CYCLES=0 and WAIT_CYCLES=7 instances for the latency sweep.
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd    = 1'b0;
  logic [3:0]  we    = 4'h0;
  logic [29:0] addr  = 30'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  logic        rd_s = 1'b0;
  logic [31:0] rdata0, rdata7;
  logic        ready0, ready7, err0, err7;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  data_mem_ctrl dut (
    .clock(clock), .reset(reset),
    .DataMem_Read(rd), .DataMem_Write(we), .DataMem_Address(addr), .DataMem_Out(wdata),
    .DataMem_In(rdata), .DataMem_Ready(ready), .Bus_Error(err)
  );

  data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .DataMem_Read(rd_s), .DataMem_Write(4'h0), .DataMem_Address(30'h1), .DataMem_Out(32'h0),
    .DataMem_In(rdata0), .DataMem_Ready(ready0), .Bus_Error(err0)
  );

  data_mem_ctrl #(.WAIT_CYCLES(7)) dut7 (
    .clock(clock), .reset(reset),
    .DataMem_Read(rd_s), .DataMem_Write(4'h0), .DataMem_Address(30'h1), .DataMem_Out(32'h0),
    .DataMem_In(rdata7), .DataMem_Ready(ready7), .Bus_Error(err7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One transaction on the default instance; request dropped in cycle 1.
  task automatic do_txn(input string tag, input logic r, input logic [3:0] w,
                        input logic [29:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_in);
    int n;
    bit got;
    rd = r; we = w; addr = a; wdata = d;
    n = 0; got = 0;
    while (!got && n < 40) begin
      step();
      n++;
      if (n == 1) begin rd = 1'b0; we = 4'h0; end
      if (ready) got = 1;
    end
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " error"}, 32'(err), 32'(exp_err));
    chk({tag, " data"}, rdata, exp_in);
    step();
    chk({tag, " ready low after"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int c, hi, p0, p1;
    int q0 [2];
    int q7 [2];
    int n0, n7;

    step(); step();
    chk("reset In", rdata, 32'h0);
    chk("reset Ready", 32'(ready), 32'd0);
    chk("reset Error", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    do_txn("wr5", 1'b0, 4'hF, 30'h5, 32'hDEADBEEF, 1'b0, 32'h0);
    do_txn("rd5", 1'b1, 4'h0, 30'h5, 32'h0, 1'b0, 32'hDEADBEEF);
    do_txn("wr5 lane2", 1'b0, 4'b0100, 30'h5, 32'h00AA0000, 1'b0, 32'hDEADBEEF);
    do_txn("rd5 merged", 1'b1, 4'h0, 30'h5, 32'h0, 1'b0, 32'hDEAABEEF);
    do_txn("rd out-of-window", 1'b1, 4'h0, 30'h400, 32'h0, 1'b1, 32'hDEAABEEF);
    do_txn("wr3", 1'b0, 4'hF, 30'h3, 32'h33333333, 1'b0, 32'hDEAABEEF);
    do_txn("rd+wr3", 1'b1, 4'h1, 30'h3, 32'h000000FF, 1'b1, 32'hDEAABEEF);
    do_txn("rd3 intact", 1'b1, 4'h0, 30'h3, 32'h0, 1'b0, 32'h33333333);
    do_txn("wr1", 1'b0, 4'hF, 30'h1, 32'h11111111, 1'b0, 32'h33333333);
    do_txn("wr2", 1'b0, 4'hF, 30'h2, 32'h22222222, 1'b0, 32'h33333333);

    // Back-to-back reads: address switched during the first Ready cycle.
    rd = 1'b1; addr = 30'h1;
    c = 0; p0 = -1; p1 = -1;
    while (p1 < 0 && c < 40) begin
      step();
      c++;
      if (ready) begin
        if (p0 < 0) begin
          p0 = c;
          chk("b2b first data", rdata, 32'h11111111);
          addr = 30'h2;
        end else begin
          p1 = c;
          chk("b2b second data", rdata, 32'h22222222);
          rd = 1'b0;
        end
      end
    end
    rd = 1'b0;
    chk("b2b first latency", 32'(p0), 32'd4);
    chk("b2b spacing", 32'(p1 - p0), 32'd5);
    step();

    do_txn("wr9 old", 1'b0, 4'hF, 30'h9, 32'h99990000, 1'b0, 32'h22222222);

    // Reset while the write sits in WAIT.
    we = 4'hF; addr = 30'h9; wdata = 32'h12345678;
    step();
    we = 4'h0;
    reset = 1'b1;
    #1;
    chk("reset in WAIT ready", 32'(ready), 32'd0);
    step();
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ready) hi++;
    end
    chk("no Ready after aborted write", 32'(hi), 32'd0);
    do_txn("rd9 old", 1'b1, 4'h0, 30'h9, 32'h0, 1'b0, 32'h99990000);

    // Reset during RESP clears Ready immediately.
    rd = 1'b1; addr = 30'h9;
    step();
    rd = 1'b0;
    step(); step(); step();
    chk("RESP reached", 32'(ready), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset in RESP ready", 32'(ready), 32'd0);
    chk("reset in RESP data", rdata, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Abandoned request: dropped in cycle 1, no follow-on transaction.
    do_txn("rd2 abandoned", 1'b1, 4'h0, 30'h2, 32'h0, 1'b0, 32'h22222222);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ready) hi++;
    end
    chk("no extra transaction", 32'(hi), 32'd0);

    // Latency sweep with a continuously held read.
    rd_s = 1'b1;
    n0 = 0; n7 = 0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (ready0 && n0 < 2) begin q0[n0] = k; n0++; end
      if (ready7 && n7 < 2) begin q7[n7] = k; n7++; end
    end
    rd_s = 1'b0;
    chk("W0 pulses seen", 32'(n0), 32'd2);
    chk("W7 pulses seen", 32'(n7), 32'd2);
    if (n0 == 2) begin
      chk("W0 first latency", 32'(q0[0]), 32'd2);
      chk("W0 spacing", 32'(q0[1] - q0[0]), 32'd3);
    end
    if (n7 == 2) begin
      chk("W7 first latency", 32'(q7[0]), 32'd9);
      chk("W7 spacing", 32'(q7[1] - q7[0]), 32'd10);
    end
    chk("W0 no error", 32'(err0), 32'd0);
    chk("W7 no error", 32'(err7), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
